axi_txn_scheduler: RTL and testbench
====================================

Name: axi_txn_scheduler

Overview:
Sequences the AXI master core's command inputs from two requesters: a write command port and a read command port. Arbitrates round-robin between the two ports and issues one transaction at a time with a start pulse. Tracks completion on the B and R channels, checks the returned ID, beat count and response, and enforces a timeout. It sits between the stimulus/BFM layer and the AXI top design's awaddr/araddr-style command inputs.

Parameters:
WIDTH, 32, address width; ID/LEN/STRB width is WIDTH/8
SIZE, 3, AxSIZE width; BURST/RESP width is SIZE-1
TIMEOUT, 256, max cycles in a wait state before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_req_valid  in  1  write command valid
wr_req_ready  out  1  write command accepted this cycle
wr_req_addr/len/size/burst/id/strb  in  WIDTH/(WIDTH/8)/SIZE/(SIZE-1)/(WIDTH/8)/(WIDTH/8)  write command fields
rd_req_valid  in  1  read command valid
rd_req_ready  out  1  read command accepted
rd_req_addr/len/size/burst/id  in  WIDTH/(WIDTH/8)/SIZE/(SIZE-1)/(WIDTH/8)  read command fields
awaddr/awlen/awsize/awburst/awid/wstrb  out  as wr_req_*  registered write command to core
araddr/arlen/arsize/arburst/arid  out  as rd_req_*  registered read command to core
wr_start  out  1  one-cycle write launch pulse
rd_start  out  1  one-cycle read launch pulse
bvalid, bready  in  1,1  B handshake observed
bid, bresp  in  WIDTH/8, SIZE-1  B channel fields
rvalid, rready, rlast  in  1,1,1  R handshake observed
rid, rresp  in  WIDTH/8, SIZE-1  R channel fields
done  out  1  one-cycle completion pulse
done_is_read  out  1  valid with done: 1 = read, 0 = write
done_resp  out  SIZE-1  final response
done_err  out  1  ID, beat-count or response error, or timeout
timeout  out  1  one-cycle pulse on abort
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- Reset values: all outputs 0, command registers 0, last_grant = READ (the first simultaneous contention goes to write), counters 0.
- Arbitration in IDLE, combinational:
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - wr_req_ready / rd_req_ready are high only in IDLE for the winner. At most one is high per cycle.
- Acceptance (valid & ready):
  - Latch the fields into the core command registers.
  - Update last_grant.
  - Go to WR_ISSUE or RD_ISSUE.
  - Command registers hold stable until the next acceptance.
- ISSUE state: assert wr_start or rd_start for exactly one cycle, then go to the WAIT state. Start follows acceptance with 1-cycle latency.
- WR_WAIT:
  - Completes on bvalid & bready.
  - done_resp = bresp.
  - done_err = (bid != awid) | (bresp != 0).
- RD_WAIT:
  - Count beats: beat_cnt (WIDTH/8+1 bits) increments on each rvalid & rready.
  - Sticky errors: rresp != 0 on any beat, or rid != arid on any beat.
  - Completes on the beat with rlast.
  - Beat-count error if the count on that beat != arlen+1.
  - done_resp = worst (max) rresp seen.
  - A beat with count already at arlen+1 and no rlast also flags an error, and waiting continues.
- Completion: in the cycle after the completing handshake, done = 1 with the done_* fields, and the state returns to IDLE. A new request can be accepted in that same IDLE cycle.
- Timeout:
  - wait_cnt clears on entry to WAIT and increments each WAIT cycle.
  - At TIMEOUT-1 with no completion, the next cycle asserts timeout = 1, done = 1, done_err = 1, done_resp = 2'b10, and returns to IDLE.
  - If completion and timeout fall in the same cycle, completion wins.
- B/R traffic observed in IDLE or ISSUE is ignored.
- Reset mid-transaction: return to IDLE next edge with all outputs cleared. No done pulse is produced for the aborted transaction.

Decomposition:
- Package axi_sched_pkg: state enum, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, and grant_e {GRANT_WR, GRANT_RD}.
- One sub-module, axi_rr_arb2: a 2-way round-robin arbiter (req[1:0], last_grant -> gnt[1:0]).

Test Plan:
- Single write: addr = 0x100, len = 3, id = 5; B returns id = 5, resp = 0 after 6 cycles -> wr_start pulses 1 cycle after accept; done = 1, done_is_read = 0, done_err = 0.
- Simultaneous wr/rd valid after reset -> write granted first, read second. Then with both held valid, grants alternate W, R, W, R.
- Read len = 3: four beats with rlast on beat 4 -> done_err = 0. Repeat with rlast on beat 3 -> done_err = 1.
- Write with bid = 6 vs awid = 5 -> done_err = 1, done_resp = 0. Read with one rresp = 2'b10 beat -> done_resp = 2'b10.
- No B response, TIMEOUT = 16 -> timeout and done pulse 16 cycles after entering WR_WAIT; done_resp = 2'b10; busy drops.
- Assert reset during RD_WAIT -> next cycle busy = 0, no done pulse; a subsequent write is accepted normally.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared types for the AXI transaction scheduler:
// FSM states, grant owner and response codes.
package axi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin arbiter.
// req_i[0] = write port, req_i[1] = read port.
module axi_rr_arb2
    import axi_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output logic [1:0] gnt_o
);

    // A lone requester wins; on contention the port not served last wins.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = (last_grant_i == GRANT_RD) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Issues one AXI write or read command at a time, then tracks
// its B/R completion, checks ID/beats/response and enforces a timeout.
module axi_txn_scheduler
    import axi_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 3,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [WIDTH-1:0]     wr_req_addr,
    input  logic [WIDTH/8-1:0]   wr_req_len,
    input  logic [SIZE-1:0]      wr_req_size,
    input  logic [SIZE-2:0]      wr_req_burst,
    input  logic [WIDTH/8-1:0]   wr_req_id,
    input  logic [WIDTH/8-1:0]   wr_req_strb,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [WIDTH-1:0]     rd_req_addr,
    input  logic [WIDTH/8-1:0]   rd_req_len,
    input  logic [SIZE-1:0]      rd_req_size,
    input  logic [SIZE-2:0]      rd_req_burst,
    input  logic [WIDTH/8-1:0]   rd_req_id,
    output logic [WIDTH-1:0]     awaddr,
    output logic [WIDTH/8-1:0]   awlen,
    output logic [SIZE-1:0]      awsize,
    output logic [SIZE-2:0]      awburst,
    output logic [WIDTH/8-1:0]   awid,
    output logic [WIDTH/8-1:0]   wstrb,
    output logic [WIDTH-1:0]     araddr,
    output logic [WIDTH/8-1:0]   arlen,
    output logic [SIZE-1:0]      arsize,
    output logic [SIZE-2:0]      arburst,
    output logic [WIDTH/8-1:0]   arid,
    output logic                 wr_start,
    output logic                 rd_start,
    input  logic                 bvalid,
    input  logic                 bready,
    input  logic [WIDTH/8-1:0]   bid,
    input  logic [SIZE-2:0]      bresp,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic                 rlast,
    input  logic [WIDTH/8-1:0]   rid,
    input  logic [SIZE-2:0]      rresp,
    output logic                 done,
    output logic                 done_is_read,
    output logic [SIZE-2:0]      done_resp,
    output logic                 done_err,
    output logic                 timeout,
    output logic                 busy
);

    localparam int IW = WIDTH / 8;
    localparam int RW = SIZE - 1;
    localparam int TW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    grant_e          last_q;
    logic [1:0]      gnt;
    logic            wr_acc, rd_acc;

    logic [TW-1:0]   wait_q, wait_d;
    logic [IW:0]     beat_q, beat_d, beat_nxt, len_p1;
    logic            rerr_q, rerr_d, r_bad;
    logic [RW-1:0]   rmax_q, rmax_d, rresp_max;
    logic            b_hs, r_hs, time_up;

    logic            done_d, done_rd_d, done_err_d, timeout_d;
    logic [RW-1:0]   done_resp_d;

    axi_rr_arb2 u_arb (
        .req_i        ({rd_req_valid, wr_req_valid}),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    assign wr_req_ready = (state_q == ST_IDLE) & gnt[0];
    assign rd_req_ready = (state_q == ST_IDLE) & gnt[1];
    assign wr_acc       = wr_req_valid & wr_req_ready;
    assign rd_acc       = rd_req_valid & rd_req_ready;

    assign wr_start = (state_q == ST_WR_ISSUE);
    assign rd_start = (state_q == ST_RD_ISSUE);
    assign busy     = (state_q != ST_IDLE);

    assign b_hs      = bvalid & bready;
    assign r_hs      = rvalid & rready;
    assign time_up   = (wait_q == TW'(TIMEOUT - 1));
    assign len_p1    = (IW+1)'(arlen) + 1'b1;
    assign beat_nxt  = beat_q + 1'b1;
    assign rresp_max = (rresp > rmax_q) ? rresp : rmax_q;
    assign r_bad     = rerr_q | (rid != arid) | (rresp != RW'(RESP_OKAY));

    // Next state, wait/beat tracking and the completion report.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        rerr_d      = rerr_q;
        rmax_d      = rmax_q;
        done_d      = 1'b0;
        done_rd_d   = 1'b0;
        done_resp_d = '0;
        done_err_d  = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    state_d = ST_WR_ISSUE;
                end else if (rd_acc) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                state_d = ST_WR_WAIT;
                wait_d  = '0;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                wait_d  = '0;
                beat_d  = '0;
                rerr_d  = 1'b0;
                rmax_d  = '0;
            end
            ST_WR_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (b_hs) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_resp_d = bresp;
                    done_err_d  = (bid != awid)
                                | (bresp != RW'(RESP_OKAY));
                end else if (time_up) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_err_d  = 1'b1;
                    done_resp_d = RW'(RESP_SLVERR);
                    timeout_d   = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (r_hs) begin
                    beat_d = beat_nxt;
                    rmax_d = rresp_max;
                    rerr_d = r_bad;
                    // An extra beat beyond the burst length is an error.
                    if (!rlast && (beat_q == len_p1)) begin
                        rerr_d = 1'b1;
                    end
                end
                if (r_hs && rlast) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_rd_d   = 1'b1;
                    done_resp_d = rresp_max;
                    done_err_d  = r_bad | (beat_nxt != len_p1);
                end else if (time_up) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_rd_d   = 1'b1;
                    done_err_d  = 1'b1;
                    done_resp_d = RW'(RESP_SLVERR);
                    timeout_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            beat_q       <= '0;
            rerr_q       <= 1'b0;
            rmax_q       <= '0;
            done         <= 1'b0;
            done_is_read <= 1'b0;
            done_resp    <= '0;
            done_err     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            beat_q       <= beat_d;
            rerr_q       <= rerr_d;
            rmax_q       <= rmax_d;
            done         <= done_d;
            done_is_read <= done_rd_d;
            done_resp    <= done_resp_d;
            done_err     <= done_err_d;
            timeout      <= timeout_d;
        end
    end

    // Command registers and grant history, updated only on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
            awid    <= '0;
            wstrb   <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arburst <= '0;
            arid    <= '0;
            last_q  <= GRANT_RD;
        end else if (wr_acc) begin
            awaddr  <= wr_req_addr;
            awlen   <= wr_req_len;
            awsize  <= wr_req_size;
            awburst <= wr_req_burst;
            awid    <= wr_req_id;
            wstrb   <= wr_req_strb;
            last_q  <= GRANT_WR;
        end else if (rd_acc) begin
            araddr  <= rd_req_addr;
            arlen   <= rd_req_len;
            arsize  <= rd_req_size;
            arburst <= rd_req_burst;
            arid    <= rd_req_id;
            last_q  <= GRANT_RD;
        end
    end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Randomized self-checking bench for axi_txn_scheduler.
// Expected results come from the transaction-level rules in ref_read.
module tb_axi_txn_scheduler;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 3;
    localparam int TIMEOUT = 16;
    localparam int IW      = WIDTH / 8;
    localparam int RW      = SIZE - 1;

    logic clk = 1'b0;
    logic reset;
    logic wr_req_valid, wr_req_ready;
    logic [WIDTH-1:0] wr_req_addr;
    logic [IW-1:0] wr_req_len, wr_req_id, wr_req_strb;
    logic [SIZE-1:0] wr_req_size;
    logic [RW-1:0] wr_req_burst;
    logic rd_req_valid, rd_req_ready;
    logic [WIDTH-1:0] rd_req_addr;
    logic [IW-1:0] rd_req_len, rd_req_id;
    logic [SIZE-1:0] rd_req_size;
    logic [RW-1:0] rd_req_burst;
    logic [WIDTH-1:0] awaddr, araddr;
    logic [IW-1:0] awlen, awid, wstrb, arlen, arid;
    logic [SIZE-1:0] awsize, arsize;
    logic [RW-1:0] awburst, arburst;
    logic wr_start, rd_start;
    logic bvalid, bready;
    logic [IW-1:0] bid;
    logic [RW-1:0] bresp;
    logic rvalid, rready, rlast;
    logic [IW-1:0] rid;
    logic [RW-1:0] rresp;
    logic done, done_is_read, done_err, timeout, busy;
    logic [RW-1:0] done_resp;

    int tests = 0;
    int fails = 0;

    logic [IW-1:0] bt_id [8];
    logic [RW-1:0] bt_resp [8];
    bit bt_gap [8];

    always #5 clk = ~clk;

    axi_txn_scheduler #(
        .WIDTH(WIDTH), .SIZE(SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_size(wr_req_size), .wr_req_burst(wr_req_burst),
        .wr_req_id(wr_req_id), .wr_req_strb(wr_req_strb),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst),
        .rd_req_id(rd_req_id),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid), .wstrb(wstrb),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid),
        .wr_start(wr_start), .rd_start(rd_start),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .rid(rid), .rresp(rresp),
        .done(done), .done_is_read(done_is_read),
        .done_resp(done_resp), .done_err(done_err),
        .timeout(timeout), .busy(busy)
    );

    task automatic idle_bus();
        bvalid = 0; bready = 0; bid = '0; bresp = '0;
        rvalid = 0; rready = 0; rlast = 0; rid = '0; rresp = '0;
    endtask

    task automatic idle_inputs();
        wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0;
        wr_req_size = '0; wr_req_burst = '0; wr_req_id = '0;
        wr_req_strb = '0;
        rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0;
        rd_req_size = '0; rd_req_burst = '0; rd_req_id = '0;
        idle_bus();
    endtask

    // Transaction-level read outcome: k beats, rlast on the k-th.
    function automatic void ref_read(input int len,
                                     input logic [IW-1:0] id,
                                     input int k,
                                     output bit err,
                                     output logic [RW-1:0] resp);
        err = (k != len + 1);
        resp = '0;
        for (int b = 0; b < k; b++) begin
            if (bt_id[b] != id) err = 1;
            if (bt_resp[b] != '0) err = 1;
            if (bt_resp[b] > resp) resp = bt_resp[b];
        end
    endfunction

    // Offer one command, wait for acceptance, check the start pulse.
    // Returns at the negedge of the first WAIT cycle.
    task automatic issue(input bit rd, input logic [WIDTH-1:0] addr,
                         input logic [IW-1:0] len,
                         input logic [IW-1:0] id);
        logic [SIZE-1:0] sz;
        logic [RW-1:0] bu;
        logic [IW-1:0] sb;
        int n;
        sz = SIZE'($urandom);
        bu = RW'($urandom);
        sb = IW'($urandom);
        if (rd) begin
            rd_req_valid = 1; rd_req_addr = addr; rd_req_len = len;
            rd_req_id = id; rd_req_size = sz; rd_req_burst = bu;
        end else begin
            wr_req_valid = 1; wr_req_addr = addr; wr_req_len = len;
            wr_req_id = id; wr_req_size = sz; wr_req_burst = bu;
            wr_req_strb = sb;
        end
        #1;
        n = 0;
        while (((rd ? rd_req_ready : wr_req_ready) !== 1'b1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL accept rd=%0d: ready stayed low for %0d cycles, required high", rd, n);
        end
        @(negedge clk);
        if (rd) rd_req_valid = 0;
        else wr_req_valid = 0;
        tests++;
        if (rd) begin
            if ({rd_start, wr_start, busy} !== 3'b101 || araddr !== addr ||
                arlen !== len || arid !== id || arsize !== sz ||
                arburst !== bu) begin
                fails++;
                $display("FAIL rd_issue: start/wr/busy=%b ar=%h/%0d/%0d/%0d/%0d required 101 %h/%0d/%0d/%0d/%0d",
                         {rd_start, wr_start, busy}, araddr, arlen, arid,
                         arsize, arburst, addr, len, id, sz, bu);
            end
        end else begin
            if ({wr_start, rd_start, busy} !== 3'b101 || awaddr !== addr ||
                awlen !== len || awid !== id || awsize !== sz ||
                awburst !== bu || wstrb !== sb) begin
                fails++;
                $display("FAIL wr_issue: start/rd/busy=%b aw=%h/%0d/%0d/%0d/%0d/%h required 101 %h/%0d/%0d/%0d/%0d/%h",
                         {wr_start, rd_start, busy}, awaddr, awlen, awid,
                         awsize, awburst, wstrb, addr, len, id, sz, bu, sb);
            end
        end
        @(negedge clk);
        tests++;
        if (wr_start !== 0 || rd_start !== 0 || busy !== 1) begin
            fails++;
            $display("FAIL start_pulse: wr_start=%b rd_start=%b busy=%b required 0 0 1",
                     wr_start, rd_start, busy);
        end
    endtask

    // Drive B after delay idle cycles (with unaccepted bvalid noise).
    task automatic finish_write(input logic [IW-1:0] id,
                                input logic [IW-1:0] bid_v,
                                input logic [RW-1:0] bresp_v,
                                input int delay);
        bit exp_err;
        for (int i = 0; i < delay; i++) begin
            bvalid = 1'($urandom); bready = 0;
            bid = IW'($urandom); bresp = RW'($urandom);
            @(negedge clk);
            tests++;
            if (done !== 0) begin
                fails++;
                $display("FAIL wr_early_done: done=%b at wait %0d required 0", done, i + 1);
            end
        end
        bvalid = 1; bready = 1; bid = bid_v; bresp = bresp_v;
        @(negedge clk);
        idle_bus();
        exp_err = (bid_v != id) || (bresp_v != '0);
        tests++;
        if (done !== 1 || done_is_read !== 0 || done_err !== exp_err ||
            done_resp !== bresp_v || timeout !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL wr_done: done/rd/err/resp/to/busy=%b/%b/%b/%0d/%b/%b required 1/0/%b/%0d/0/0",
                     done, done_is_read, done_err, done_resp, timeout, busy,
                     exp_err, bresp_v);
        end
        @(negedge clk);
        tests++;
        if (done !== 0) begin
            fails++;
            $display("FAIL wr_done_pulse: done=%b one cycle later required 0", done);
        end
    endtask

    // Drive k beats from bt_* (rlast on beat k), optional stall cycles.
    task automatic finish_read(input int len, input logic [IW-1:0] id,
                               input int k);
        bit exp_err;
        logic [RW-1:0] exp_resp;
        ref_read(len, id, k, exp_err, exp_resp);
        for (int b = 0; b < k; b++) begin
            if (bt_gap[b]) begin
                rvalid = 1; rready = 0; rlast = 1;
                rid = ~id; rresp = RW'(3);
                @(negedge clk);
            end
            rvalid = 1; rready = 1; rid = bt_id[b]; rresp = bt_resp[b];
            rlast = (b == k - 1);
            @(negedge clk);
            if (b != k - 1) begin
                tests++;
                if (done !== 0) begin
                    fails++;
                    $display("FAIL rd_early_done: done=%b after beat %0d required 0", done, b + 1);
                end
            end
        end
        idle_bus();
        tests++;
        if (done !== 1 || done_is_read !== 1 || done_err !== exp_err ||
            done_resp !== exp_resp || timeout !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL rd_done len=%0d k=%0d: done/rd/err/resp/to/busy=%b/%b/%b/%0d/%b/%b required 1/1/%b/%0d/0/0",
                     len, k, done, done_is_read, done_err, done_resp,
                     timeout, busy, exp_err, exp_resp);
        end
        @(negedge clk);
        tests++;
        if (done !== 0) begin
            fails++;
            $display("FAIL rd_done_pulse: done=%b one cycle later required 0", done);
        end
    endtask

    task automatic clean_beats(input logic [IW-1:0] id);
        for (int b = 0; b < 8; b++) begin
            bt_id[b] = id; bt_resp[b] = '0; bt_gap[b] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        tests++;
        if ({done, done_is_read, done_resp, done_err, timeout, busy,
             wr_start, rd_start, wr_req_ready, rd_req_ready} !== '0) begin
            fails++;
            $display("FAIL reset_status: outputs=%b required all 0",
                     {done, done_is_read, done_resp, done_err, timeout,
                      busy, wr_start, rd_start, wr_req_ready, rd_req_ready});
        end
        tests++;
        if ({awaddr, awlen, awsize, awburst, awid, wstrb} !== '0 ||
            {araddr, arlen, arsize, arburst, arid} !== '0) begin
            fails++;
            $display("FAIL reset_cmd: aw=%h ar=%h required 0",
                     {awaddr, awlen, awid}, {araddr, arlen, arid});
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        issue(0, 32'h100, 4'd3, 4'd5);
        finish_write(4'd5, 4'd5, 2'd0, 6);
    endtask

    task automatic test_write_errors();
        issue(0, 32'h300, 4'd3, 4'd5);
        finish_write(4'd5, 4'd6, 2'd0, 2);
        issue(0, 32'h340, 4'd0, 4'd2);
        finish_write(4'd2, 4'd2, 2'd2, 1);
    endtask

    task automatic test_read_beats();
        clean_beats(4'd7);
        issue(1, 32'h2000, 4'd3, 4'd7);
        finish_read(3, 4'd7, 4);
        issue(1, 32'h2040, 4'd3, 4'd7);
        finish_read(3, 4'd7, 3);
        bt_resp[1] = 2'b10;
        issue(1, 32'h2080, 4'd3, 4'd7);
        finish_read(3, 4'd7, 4);
        clean_beats(4'd7);
        bt_id[2] = 4'd8;
        issue(1, 32'h20c0, 4'd3, 4'd7);
        finish_read(3, 4'd7, 4);
    endtask

    task automatic test_contention();
        bit last_rd;
        bit exp_wr;
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
        last_rd = 1;
        wr_req_valid = 1; wr_req_addr = 32'h600; wr_req_id = 4'd1;
        rd_req_valid = 1; rd_req_addr = 32'h700; rd_req_id = 4'd2;
        for (int i = 0; i < 4; i++) begin
            exp_wr = last_rd;
            #1;
            tests++;
            if (wr_req_ready !== exp_wr || rd_req_ready !== !exp_wr) begin
                fails++;
                $display("FAIL grant %0d: wr_ready=%b rd_ready=%b required %b %b",
                         i, wr_req_ready, rd_req_ready, exp_wr, !exp_wr);
            end
            @(negedge clk);
            tests++;
            if (wr_start !== exp_wr || rd_start !== !exp_wr ||
                wr_req_ready !== 0 || rd_req_ready !== 0) begin
                fails++;
                $display("FAIL grant_start %0d: wr/rd start=%b%b readies=%b%b required %b%b 00",
                         i, wr_start, rd_start, wr_req_ready, rd_req_ready,
                         exp_wr, !exp_wr);
            end
            @(negedge clk);
            if (exp_wr) begin
                bvalid = 1; bready = 1; bid = 4'd1; bresp = '0;
            end else begin
                rvalid = 1; rready = 1; rlast = 1; rid = 4'd2; rresp = '0;
            end
            @(negedge clk);
            idle_bus();
            tests++;
            if (done !== 1 || done_is_read !== !exp_wr || done_err !== 0) begin
                fails++;
                $display("FAIL grant_done %0d: done/rd/err=%b/%b/%b required 1/%b/0",
                         i, done, done_is_read, done_err, !exp_wr);
            end
            last_rd = !exp_wr;
        end
        wr_req_valid = 0;
        rd_req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        issue(0, 32'h800, 4'd1, 4'd4);
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 0 || busy !== 1) begin
                fails++;
                $display("FAIL to_wait %0d: done=%b busy=%b required 0 1", i, done, busy);
            end
        end
        @(negedge clk);
        tests++;
        if (timeout !== 1 || done !== 1 || done_err !== 1 ||
            done_resp !== 2'b10 || busy !== 0 || done_is_read !== 0) begin
            fails++;
            $display("FAIL to_abort: to/done/err/resp/busy/rd=%b/%b/%b/%0d/%b/%b required 1/1/1/2/0/0",
                     timeout, done, done_err, done_resp, busy, done_is_read);
        end
        @(negedge clk);
        tests++;
        if (timeout !== 0 || done !== 0) begin
            fails++;
            $display("FAIL to_pulse: timeout=%b done=%b required 0 0", timeout, done);
        end
        issue(0, 32'h840, 4'd1, 4'd4);
        finish_write(4'd4, 4'd4, 2'd0, TIMEOUT - 1);
    endtask

    task automatic test_reset_mid_read();
        issue(1, 32'h400, 4'd3, 4'd9);
        rvalid = 1; rready = 1; rid = 4'd9; rresp = '0; rlast = 0;
        @(negedge clk);
        idle_bus();
        reset = 1;
        @(negedge clk);
        tests++;
        if (busy !== 0 || done !== 0 || timeout !== 0 || rd_start !== 0 ||
            araddr !== '0 || arid !== '0) begin
            fails++;
            $display("FAIL mid_reset: busy/done/to/start=%b/%b/%b/%b araddr=%h required 0/0/0/0 0",
                     busy, done, timeout, rd_start, araddr);
        end
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 0 || busy !== 0) begin
                fails++;
                $display("FAIL mid_reset_quiet %0d: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
        issue(0, 32'h500, 4'd1, 4'd3);
        finish_write(4'd3, 4'd3, 2'd0, 2);
    endtask

    task automatic test_random();
        logic [IW-1:0] id, bid_v;
        logic [RW-1:0] bresp_v;
        int len, k;
        for (int it = 0; it < 40; it++) begin
            id = IW'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                len = $urandom_range(3, 0);
                case ($urandom_range(3, 0))
                    0: k = len + 2;
                    1: k = (len > 0) ? len : len + 2;
                    default: k = len + 1;
                endcase
                for (int b = 0; b < 8; b++) begin
                    bt_id[b] = ($urandom_range(5, 0) == 0) ? (id ^ IW'(1)) : id;
                    bt_resp[b] = ($urandom_range(4, 0) == 0) ? RW'($urandom) : '0;
                    bt_gap[b] = ($urandom_range(2, 0) == 0);
                end
                issue(1, $urandom, IW'(len), id);
                finish_read(len, id, k);
            end else begin
                bid_v = ($urandom_range(3, 0) == 0) ? (id ^ IW'(1)) : id;
                bresp_v = ($urandom_range(3, 0) == 0) ? RW'($urandom) : '0;
                issue(0, $urandom, IW'($urandom), id);
                finish_write(id, bid_v, bresp_v, $urandom_range(11, 0));
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_single_write();
        test_write_errors();
        test_read_beats();
        test_contention();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
